// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the RV32I multi-cycle sequencer.
// Contents: FSM state encoding, RV32I major opcodes, opcode-class enum,
// wb_sel / pc_src encodings and small per-class decode helpers.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_FAULT  = 3'd6
  } state_t;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // CLS_ILLEGAL is zero so the cleared opcode latch decodes as illegal.
  typedef enum logic [3:0] {
    CLS_ILLEGAL = 4'd0,
    CLS_OP      = 4'd1,
    CLS_OP_IMM  = 4'd2,
    CLS_LOAD    = 4'd3,
    CLS_STORE   = 4'd4,
    CLS_BRANCH  = 4'd5,
    CLS_JAL     = 4'd6,
    CLS_JALR    = 4'd7,
    CLS_LUI     = 4'd8,
    CLS_AUIPC   = 4'd9,
    CLS_FENCE   = 4'd10,
    CLS_SYSTEM  = 4'd11
  } op_class_t;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_IMM  = 2'b11;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JALR   = 2'b10;

  // ALU operand B is the immediate for everything except register-register
  // ops, branch compares, jal and fence.
  function automatic logic alu_b_is_imm(input op_class_t cls);
    case (cls)
      CLS_OP_IMM, CLS_LOAD, CLS_STORE, CLS_JALR,
      CLS_LUI, CLS_AUIPC: alu_b_is_imm = 1'b1;
      default:            alu_b_is_imm = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] wb_select(input op_class_t cls);
    case (cls)
      CLS_LOAD:          wb_select = WB_LOAD;
      CLS_JAL, CLS_JALR: wb_select = WB_PC4;
      CLS_LUI:           wb_select = WB_IMM;
      default:           wb_select = WB_ALU;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_op_classify.sv
// op_classify: combinational RV32I opcode classifier.
// Ports: opcode (inst[6:0]), funct3 (inst[14:12]) in;
//        op_class (class enum), legal (opcode and funct3 form a valid RV32I
//        instruction, ecall/ebreak included) out.
module op_classify
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output op_class_t  op_class,
  output logic       legal
);

  // Map the major opcode to a class; reserved funct3 codes are illegal.
  always_comb begin
    op_class = CLS_ILLEGAL;
    case (opcode)
      OPC_OP:       op_class = CLS_OP;
      OPC_OP_IMM:   op_class = CLS_OP_IMM;
      OPC_LOAD:     op_class = (funct3 == 3'b011 || funct3[2:1] == 2'b11)
                               ? CLS_ILLEGAL : CLS_LOAD;
      OPC_STORE:    op_class = (funct3 <= 3'b010) ? CLS_STORE : CLS_ILLEGAL;
      OPC_BRANCH:   op_class = (funct3[2:1] == 2'b01) ? CLS_ILLEGAL : CLS_BRANCH;
      OPC_JAL:      op_class = CLS_JAL;
      OPC_JALR:     op_class = (funct3 == 3'b000) ? CLS_JALR : CLS_ILLEGAL;
      OPC_LUI:      op_class = CLS_LUI;
      OPC_AUIPC:    op_class = CLS_AUIPC;
      OPC_MISC_MEM: op_class = CLS_FENCE;
      OPC_SYSTEM:   op_class = CLS_SYSTEM;
      default:      op_class = CLS_ILLEGAL;
    endcase
  end

  assign legal = (op_class != CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH -> DECODE -> EXEC -> (MEM) -> WB sequencer for an
// RV32I core. Owns every write strobe, counts retired instructions and traps
// illegal opcodes, ecall/ebreak and memory timeouts.
// Ports: clk, rst (sync, active-low), inst, do_branch, imem_ack, dmem_ack in;
//        imem_req, dmem_req, dmem_we, ir_load, reg_write, wb_sel, alu_src_b,
//        alu_pc_a, pc_we, pc_src, state_o, halted, fault, instret out.
// Optional: define SINGLE_STEP_EN to add input 'step'; each fetch then waits
//        for a step pulse seen while in FETCH.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          inst,
  input  logic                 do_branch,
`ifdef SINGLE_STEP_EN
  input  logic                 step,
`endif
  output logic                 imem_req,
  input  logic                 imem_ack,
  output logic                 dmem_req,
  output logic                 dmem_we,
  input  logic                 dmem_ack,
  output logic                 ir_load,
  output logic                 reg_write,
  output logic [1:0]           wb_sel,
  output logic                 alu_src_b,
  output logic                 alu_pc_a,
  output logic                 pc_we,
  output logic [1:0]           pc_src,
  output logic [2:0]           state_o,
  output logic                 halted,
  output logic                 fault,
  output logic [INSTRET_W-1:0] instret
);

  localparam int              CNT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

  state_t           state;
  op_class_t        cls_q;
  logic             legal_q;
  logic [CNT_W-1:0] wait_cnt;
  op_class_t        cls_dec;
  logic             legal_dec;
  logic             fetch_ok;
  logic             is_store;
  logic             unused_inst;

  op_classify u_classify (
    .opcode   (inst[6:0]),
    .funct3   (inst[14:12]),
    .op_class (cls_dec),
    .legal    (legal_dec)
  );

  // Only the opcode and funct3 fields matter to the sequencer.
  assign unused_inst = ^{inst[31:15], inst[11:7]};
  assign is_store    = (cls_q == CLS_STORE);
  assign state_o     = state;

`ifdef SINGLE_STEP_EN
  logic step_pend;

  // Remember a step pulse seen in FETCH until the fetched word is latched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      step_pend <= 1'b0;
    end else if (ir_load) begin
      step_pend <= 1'b0;
    end else if (step && state == ST_FETCH) begin
      step_pend <= 1'b1;
    end else begin
      step_pend <= step_pend;
    end
  end

  assign fetch_ok = step_pend | step;
`else
  assign fetch_ok = 1'b1;
`endif

  // Sequencer state, opcode latch, wait counter and status registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_FETCH;
      cls_q    <= CLS_ILLEGAL;
      legal_q  <= 1'b0;
      wait_cnt <= '0;
      halted   <= 1'b0;
      fault    <= 1'b0;
      instret  <= '0;
    end else begin
      // Every retiring cycle is exactly the one that updates the PC.
      if (pc_we) begin
        instret <= instret + INSTRET_W'(1);
      end
      case (state)
        ST_FETCH: begin
          if (ir_load) begin
            cls_q   <= cls_dec;
            legal_q <= legal_dec;
            state   <= ST_DECODE;
          end else if (imem_req) begin
            // The limit cycle still accepts an ack; only a miss there faults.
            if (wait_cnt == CNT_LIMIT) begin
              state <= ST_FAULT;
              fault <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + CNT_W'(1);
            end
          end
        end
        ST_DECODE: begin
          if (cls_q == CLS_SYSTEM) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else if (legal_q) begin
            state <= ST_EXEC;
          end else begin
            state <= ST_FAULT;
            fault <= 1'b1;
          end
        end
        ST_EXEC: begin
          wait_cnt <= '0;
          if (cls_q == CLS_BRANCH) begin
            state <= ST_FETCH;
          end else if (cls_q == CLS_LOAD || is_store) begin
            state <= ST_MEM;
          end else begin
            state <= ST_WB;
          end
        end
        ST_MEM: begin
          if (dmem_ack) begin
            wait_cnt <= '0;
            state    <= is_store ? ST_FETCH : ST_WB;
          end else if (wait_cnt == CNT_LIMIT) begin
            state <= ST_FAULT;
            fault <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_WB: begin
          wait_cnt <= '0;
          state    <= ST_FETCH;
        end
        ST_HALT:  state <= ST_HALT;
        ST_FAULT: state <= ST_FAULT;
        default: begin
          state <= ST_FAULT;
          fault <= 1'b1;
        end
      endcase
    end
  end

  // Strobe decode from state, latched class and acks; all low during reset.
  always_comb begin
    imem_req  = 1'b0;
    ir_load   = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_write = 1'b0;
    wb_sel    = WB_ALU;
    alu_src_b = 1'b0;
    alu_pc_a  = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PC_PLUS4;
    if (rst) begin
      // Operand selects stay valid from EXEC through WB so an unregistered
      // ALU result still holds the address in MEM and the result in WB.
      if (state == ST_EXEC || state == ST_MEM || state == ST_WB) begin
        alu_src_b = alu_b_is_imm(cls_q);
        alu_pc_a  = (cls_q == CLS_AUIPC);
      end else begin
        alu_src_b = 1'b0;
      end
      case (state)
        ST_FETCH: begin
          imem_req = fetch_ok;
          ir_load  = fetch_ok & imem_ack;
        end
        ST_EXEC: begin
          if (cls_q == CLS_BRANCH) begin
            pc_we  = 1'b1;
            pc_src = do_branch ? PC_BRANCH : PC_PLUS4;
          end else begin
            pc_we = 1'b0;
          end
        end
        ST_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = is_store;
          pc_we    = is_store & dmem_ack;
        end
        ST_WB: begin
          reg_write = 1'b1;
          pc_we     = 1'b1;
          wb_sel    = wb_select(cls_q);
          if (cls_q == CLS_JAL) begin
            pc_src = PC_BRANCH;
          end else if (cls_q == CLS_JALR) begin
            pc_src = PC_JALR;
          end else begin
            pc_src = PC_PLUS4;
          end
        end
        default: pc_we = 1'b0;
      endcase
    end else begin
      imem_req = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected strobe vectors are
// queued as each step is driven and popped when the outputs are sampled.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic       imem_req;
    logic       ir_load;
    logic       dmem_req;
    logic       dmem_we;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       alu_src_b;
    logic       alu_pc_a;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       halted;
    logic       fault;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rst_drv = 1'b0;
  logic [31:0] inst = 32'h0;
  logic        do_branch = 1'b0;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        imem_req, dmem_req, dmem_we, ir_load, reg_write;
  logic [1:0]  wb_sel, pc_src;
  logic        alu_src_b, alu_pc_a, pc_we, halted, fault;
  logic [2:0]  state_o;
  logic [31:0] instret;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(15), .INSTRET_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .inst      (inst),
    .do_branch (do_branch),
`ifdef SINGLE_STEP_EN
    .step      (1'b1),
`endif
    .imem_req  (imem_req),
    .imem_ack  (imem_ack),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_ack  (dmem_ack),
    .ir_load   (ir_load),
    .reg_write (reg_write),
    .wb_sel    (wb_sel),
    .alu_src_b (alu_src_b),
    .alu_pc_a  (alu_pc_a),
    .pc_we     (pc_we),
    .pc_src    (pc_src),
    .state_o   (state_o),
    .halted    (halted),
    .fault     (fault),
    .instret   (instret)
  );

  always #5 clk = ~clk;

  function automatic obs_t ex(input logic [2:0] st, input logic ireq, input logic irl,
                              input logic dreq, input logic dwe, input logic rw,
                              input logic [1:0] wbs, input logic asb, input logic apa,
                              input logic pwe, input logic [1:0] psrc,
                              input logic h, input logic f);
    ex = {st, ireq, irl, dreq, dwe, rw, wbs, asb, apa, pwe, psrc, h, f};
  endfunction

  // One clock: drive at the falling edge, queue the expectation, sample 1ns later.
  task automatic step(input logic [31:0] iv, input logic ia, input logic da,
                      input logic br, input obs_t e, input string tag);
    obs_t got;
    obs_t want;
    @(negedge clk);
    rst = rst_drv;
    inst = iv;
    imem_ack = ia;
    dmem_ack = da;
    do_branch = br;
    exp_q.push_back(e);
    #1;
    got = {state_o, imem_req, ir_load, dmem_req, dmem_we, reg_write, wb_sel,
           alu_src_b, alu_pc_a, pc_we, pc_src, halted, fault};
    want = exp_q.pop_front();
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Counter check after the edge that closes the previous step.
  task automatic chk_instret(input logic [31:0] want, input string tag);
    @(posedge clk);
    #1;
    checks++;
    assert (instret === want) else begin
      errors++;
      $error("FAIL %s: observed instret %0d expected %0d", tag, instret, want);
    end
  endtask

  task automatic fetch_decode(input logic [31:0] iv, input string tag);
    step(iv, 1'b1, 1'b0, 1'b0, ex(3'd0,1,1,0,0,0,2'b00,0,0,0,2'b00,0,0), {tag, "_fetch"});
    // stray imem_ack in DECODE must be ignored; inst=0 shows the class is latched
    step(32'h0, 1'b1, 1'b0, 1'b0, ex(3'd1,0,0,0,0,0,2'b00,0,0,0,2'b00,0,0), {tag, "_decode"});
  endtask

  initial begin
    // reset held for three cycles with acks high: no strobes
    for (int i = 0; i < 3; i++) begin
      step(32'h00500093, 1'b1, 1'b1, 1'b1, ex(3'd0,0,0,0,0,0,2'b00,0,0,0,2'b00,0,0), "reset_strobes");
    end
    chk_instret(32'd0, "reset_instret");
    rst_drv = 1'b1;
    step(32'h0, 1'b0, 1'b0, 1'b0, ex(3'd0,1,0,0,0,0,2'b00,0,0,0,2'b00,0,0), "release_fetch");

    // addi x1,x0,5
    fetch_decode(32'h00500093, "addi");
    step(32'h0, 1'b0, 1'b0, 1'b0, ex(3'd2,0,0,0,0,0,2'b00,1,0,0,2'b00,0,0), "addi_exec");
    step(32'h0, 1'b0, 1'b1, 1'b0, ex(3'd4,0,0,0,0,1,2'b00,1,0,1,2'b00,0,0), "addi_wb");
    chk_instret(32'd1, "instret_addi");

    // beq taken, then not taken
    fetch_decode(32'h00000063, "beq_t");
    step(32'h0, 1'b0, 1'b0, 1'b1, ex(3'd2,0,0,0,0,0,2'b00,0,0,1,2'b01,0,0), "beq_t_exec");
    chk_instret(32'd2, "instret_beq_t");
    fetch_decode(32'h00000063, "beq_nt");
    step(32'h0, 1'b0, 1'b0, 1'b0, ex(3'd2,0,0,0,0,0,2'b00,0,0,1,2'b00,0,0), "beq_nt_exec");
    chk_instret(32'd3, "instret_beq_nt");

    // lw with dmem_ack after three wait cycles
    fetch_decode(32'h00002083, "lw");
    step(32'h0, 1'b0, 1'b0, 1'b0, ex(3'd2,0,0,0,0,0,2'b00,1,0,0,2'b00,0,0), "lw_exec");
    for (int i = 0; i < 3; i++) begin
      step(32'h0, 1'b0, 1'b0, 1'b0, ex(3'd3,0,0,1,0,0,2'b00,1,0,0,2'b00,0,0), "lw_mem_wait");
    end
    step(32'h0, 1'b0, 1'b1, 1'b0, ex(3'd3,0,0,1,0,0,2'b00,1,0,0,2'b00,0,0), "lw_mem_ack");
    step(32'h0, 1'b0, 1'b0, 1'b0, ex(3'd4,0,0,0,0,1,2'b01,1,0,1,2'b00,0,0), "lw_wb");
    chk_instret(32'd4, "instret_lw");

    // sw, zero wait: retires from MEM
    fetch_decode(32'h00102023, "sw");
    step(32'h0, 1'b0, 1'b0, 1'b0, ex(3'd2,0,0,0,0,0,2'b00,1,0,0,2'b00,0,0), "sw_exec");
    step(32'h0, 1'b0, 1'b1, 1'b0, ex(3'd3,0,0,1,1,0,2'b00,1,0,1,2'b00,0,0), "sw_mem_ack");
    chk_instret(32'd5, "instret_sw");

    // jal, jalr, lui, auipc
    fetch_decode(32'h0000006F, "jal");
    step(32'h0, 1'b0, 1'b0, 1'b0, ex(3'd2,0,0,0,0,0,2'b00,0,0,0,2'b00,0,0), "jal_exec");
    step(32'h0, 1'b0, 1'b0, 1'b0, ex(3'd4,0,0,0,0,1,2'b10,0,0,1,2'b01,0,0), "jal_wb");
    fetch_decode(32'h00008067, "jalr");
    step(32'h0, 1'b0, 1'b0, 1'b0, ex(3'd2,0,0,0,0,0,2'b00,1,0,0,2'b00,0,0), "jalr_exec");
    step(32'h0, 1'b0, 1'b0, 1'b0, ex(3'd4,0,0,0,0,1,2'b10,1,0,1,2'b10,0,0), "jalr_wb");
    fetch_decode(32'h123450B7, "lui");
    step(32'h0, 1'b0, 1'b0, 1'b0, ex(3'd2,0,0,0,0,0,2'b00,1,0,0,2'b00,0,0), "lui_exec");
    step(32'h0, 1'b0, 1'b0, 1'b0, ex(3'd4,0,0,0,0,1,2'b11,1,0,1,2'b00,0,0), "lui_wb");
    fetch_decode(32'h00000097, "auipc");
    step(32'h0, 1'b0, 1'b0, 1'b0, ex(3'd2,0,0,0,0,0,2'b00,1,1,0,2'b00,0,0), "auipc_exec");
    step(32'h0, 1'b0, 1'b0, 1'b0, ex(3'd4,0,0,0,0,1,2'b00,1,1,1,2'b00,0,0), "auipc_wb");
    chk_instret(32'd9, "instret_auipc");

    // ack on the limit cycle (wait counter at 15) is accepted
    for (int i = 0; i < 15; i++) begin
      step(32'h0, 1'b0, 1'b0, 1'b0, ex(3'd0,1,0,0,0,0,2'b00,0,0,0,2'b00,0,0), "limit_wait");
    end
    fetch_decode(32'h00500093, "limit_addi");
    step(32'h0, 1'b0, 1'b0, 1'b0, ex(3'd2,0,0,0,0,0,2'b00,1,0,0,2'b00,0,0), "limit_exec");
    step(32'h0, 1'b0, 1'b0, 1'b0, ex(3'd4,0,0,0,0,1,2'b00,1,0,1,2'b00,0,0), "limit_wb");
    chk_instret(32'd10, "instret_limit");

    // imem_ack never arrives: 16 request cycles then FAULT, which is absorbing
    for (int i = 0; i < 16; i++) begin
      step(32'h0, 1'b0, 1'b0, 1'b0, ex(3'd0,1,0,0,0,0,2'b00,0,0,0,2'b00,0,0), "timeout_wait");
    end
    for (int i = 0; i < 3; i++) begin
      step(32'h00500093, 1'b1, 1'b1, 1'b1, ex(3'd6,0,0,0,0,0,2'b00,0,0,0,2'b00,0,1), "timeout_fault");
    end
    chk_instret(32'd10, "instret_fault");

    // reset recovers from FAULT
    rst_drv = 1'b0;
    step(32'h0, 1'b0, 1'b0, 1'b0, ex(3'd6,0,0,0,0,0,2'b00,0,0,0,2'b00,0,1), "reset_in_fault");
    rst_drv = 1'b1;
    step(32'h0, 1'b0, 1'b0, 1'b0, ex(3'd0,1,0,0,0,0,2'b00,0,0,0,2'b00,0,0), "fault_cleared");

    // ecall halts and is not counted
    fetch_decode(32'h00000073, "ecall");
    for (int i = 0; i < 2; i++) begin
      step(32'h00500093, 1'b1, 1'b1, 1'b0, ex(3'd5,0,0,0,0,0,2'b00,0,0,0,2'b00,1,0), "ecall_halt");
    end
    chk_instret(32'd0, "instret_ecall");

    // reset, then opcode 0x7F faults from DECODE
    rst_drv = 1'b0;
    step(32'h0, 1'b0, 1'b0, 1'b0, ex(3'd5,0,0,0,0,0,2'b00,0,0,0,2'b00,1,0), "reset_in_halt");
    rst_drv = 1'b1;
    step(32'h0, 1'b0, 1'b0, 1'b0, ex(3'd0,1,0,0,0,0,2'b00,0,0,0,2'b00,0,0), "halt_cleared");
    fetch_decode(32'h0000007F, "illegal");
    step(32'h0, 1'b0, 1'b0, 1'b0, ex(3'd6,0,0,0,0,0,2'b00,0,0,0,2'b00,0,1), "illegal_fault");
    chk_instret(32'd0, "instret_illegal");

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the RV32I core. It drives the instruction decoder/register file, PC, ALU-operand muxes and the instruction/data memory handshakes through FETCH → DECODE → EXEC → (MEM) → WB. It sits between the memories and the decoder/ALU datapath and owns every write strobe in the core. It also keeps a retired-instruction counter and traps illegal opcodes, ecall and memory timeouts.

Parameters:
MEM_TIMEOUT, 15, maximum wait cycles for imem_ack/dmem_ack before FAULT; counter width is $clog2(MEM_TIMEOUT+1).
INSTRET_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  synchronous reset, active-low
inst  in  32  word from instruction memory; only [6:0] and [14:12] are used
do_branch  in  1  branch-taken flag from the decoder, valid in EXEC
imem_req  out  1  instruction fetch request
imem_ack  in  1  instruction word valid this cycle
dmem_req  out  1  data access request
dmem_we  out  1  1 = store, 0 = load; valid with dmem_req
dmem_ack  in  1  data access complete
ir_load  out  1  one-cycle strobe that latches inst into the instruction register
reg_write  out  1  regWrite to the register file
wb_sel  out  2  00 ALU, 01 load data, 10 PC+4, 11 imm32 (lui)
alu_src_b  out  1  0 = rs2Data, 1 = imm32
alu_pc_a  out  1  1 = ALU operand A is PC (auipc)
pc_we  out  1  PC update strobe
pc_src  out  2  00 PC+4, 01 PC+imm32 (branch/jal), 10 (rs1+imm32)&~1 (jalr)
state_o  out  3  current state code, for debug
halted  out  1  sticky, set by ecall/ebreak
fault  out  1  sticky, set by illegal opcode or timeout
instret  out  INSTRET_W  count of retired instructions

Behaviour:
- Reset (rst=0 at posedge): state←FETCH, opcode latch←0, wait counter←0, halted←0, fault←0, instret←0. While rst=0, every output strobe is forced to 0. Reset overrides any state, including mid-handshake; an in-flight request is dropped.
- Outputs are combinational from state, the latched opcode class and the ack inputs. halted, fault and instret are registers.
- FETCH: imem_req=1 until imem_ack=1. An ack in the same cycle as the request counts. On ack: ir_load=1 for exactly that cycle, the opcode class is latched from inst[6:0]/[14:12], next state is DECODE.
- DECODE: one cycle, no strobes; covers the decoder's registered imm32. Next state depends on the opcode:
  - legal RV32I opcode → EXEC
  - 1110011 (ecall/ebreak) → HALT
  - anything else → FAULT
- EXEC: one cycle. alu_src_b/alu_pc_a are set per class.
  - Branch: pc_we=1, pc_src=01 if do_branch else 00, instret+1, next FETCH.
  - Load or store → MEM. All other classes → WB.
- MEM: dmem_req=1 with dmem_we = store, held until dmem_ack.
  - Store ack: pc_we=1, pc_src=00, instret+1, next FETCH.
  - Load ack → WB.
- WB: reg_write=1 for exactly one cycle, pc_we=1, instret+1, next FETCH.
  - wb_sel: ALU for op/op-imm/auipc, load for loads, PC+4 for jal/jalr, imm for lui.
  - pc_src: 01 for jal, 10 for jalr, otherwise 00.
- Writes to x0 are not filtered here; the register file discards them.
- Latency with zero-wait memory: branch 3, ALU/jump 4, store 4, load 5 cycles.
- Timeout: the wait counter clears on entry to FETCH/MEM and increments each cycle without ack. If it reaches MEM_TIMEOUT with no ack, the next state is FAULT. An ack arriving on the limit cycle wins.
- HALT and FAULT are absorbing until reset. No strobes are asserted; halted or fault = 1.
- instret wraps modulo 2^INSTRET_W. ecall and faulting instructions are not counted.
- Acks outside their request state are ignored.

Optional Feature:
SINGLE_STEP_EN. When defined, input port step (1 bit) is added. FETCH does not raise imem_req until a step=1 cycle has been seen since entering FETCH; the pending step is held in a flag that clears on ir_load. When undefined, the port is absent and FETCH requests immediately.

Decomposition:
- Package ctrl_pkg holds:
  - state enum: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, FAULT=6
  - RV32I opcode constants
  - opcode-class enum
  - wb_sel and pc_src encodings
- One sub-module, op_classify: purely combinational, maps inst[6:0] to class + legal flag.

Test Plan:
- Reset: hold rst=0 for 3 cycles → all strobes 0. Release → imem_req=1 on the first cycle, state_o=0.
- Zero-wait addi x1,x0,5 (0x00500093) → ir_load on cycle 1, reg_write on cycle 4 with wb_sel=00, alu_src_b=1. instret=1 after pc_we.
- beq with do_branch=1 → pc_we with pc_src=01 in EXEC, 3-cycle instruction. Repeat with do_branch=0 → pc_src=00.
- lw with dmem_ack delayed 3 cycles → dmem_req high for 4 cycles, dmem_we=0, then WB with wb_sel=01. Total 8 cycles.
- imem_ack never asserted → fault=1 after 15 wait cycles and stays set. Asserting rst=0 clears it to FETCH.
- inst=0x00000073 → HALT, halted=1, instret unchanged. Opcode 0x7F → FAULT.
